// File: rtl/riscv_defs.sv
// Shared RV32I definitions used by the writeback stage: writeback selectors,
// writeback FSM states and load funct3 encodings.
package riscv_defs;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_ALU  = 2'b01,
    WB_LOAD = 2'b10,
    WB_RET  = 2'b11
  } wb_sel_t;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: selects the addressed byte/halfword/word and extends it.
// Misalignment flagging is compiled in only with WB_MISALIGN_CHECK_EN.
module load_align
  import riscv_defs::*;
#(
  parameter int NB_WORD = 32
) (
  input  logic [NB_WORD-1:0] i_rdata,
  input  logic [2:0]         i_funct3,
  input  logic [1:0]         i_addr,
  output logic [NB_WORD-1:0] o_value,
  output logic               o_misaligned
);

  function automatic logic [NB_WORD-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]         bs;
    logic signed [NB_WORD-1:0] r;
    bs = b;
    r  = NB_WORD'(bs);
    return sgn ? r : NB_WORD'(b);
  endfunction

  function automatic logic [NB_WORD-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]        hs;
    logic signed [NB_WORD-1:0] r;
    hs = h;
    r  = NB_WORD'(hs);
    return sgn ? r : NB_WORD'(h);
  endfunction

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign sel_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

  // Reserved funct3 codes fall through to the word path.
  always_comb begin
    o_value = i_rdata;
    case (i_funct3)
      F3_LB:   o_value = ext_byte(sel_byte, 1'b1);
      F3_LBU:  o_value = ext_byte(sel_byte, 1'b0);
      F3_LH:   o_value = ext_half(sel_half, 1'b1);
      F3_LHU:  o_value = ext_half(sel_half, 1'b0);
      default: o_value = i_rdata;
    endcase
  end

`ifdef WB_MISALIGN_CHECK_EN
  always_comb begin
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_LB, F3_LBU: o_misaligned = 1'b0;
      F3_LH, F3_LHU: o_misaligned = i_addr[0];
      default:       o_misaligned = (i_addr != 2'b00);
    endcase
  end
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registers ALU/return-address writes and waits for load data.
// Optional misaligned-load trapping via WB_MISALIGN_CHECK_EN.
module wb_stage
  import riscv_defs::*;
#(
  parameter int NB_WORD    = 32,
  parameter int NB_ADDR    = 32,
  parameter int NB_OPERAND = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NB_OPERAND-1:0] i_rd,
  input  logic [1:0]            i_wb_sel,
  input  logic [2:0]            i_funct3,
  input  logic [NB_WORD-1:0]    i_alu_result,
  input  logic [NB_ADDR-1:0]    i_ret_addr,
  input  logic                  i_dmem_rvalid,
  input  logic [NB_WORD-1:0]    i_dmem_rdata,
  output logic                  o_write,
  output logic [NB_ADDR-1:0]    o_wr_addr,
  output logic [NB_WORD-1:0]    o_wr_value,
  output logic                  o_wr_retaddr,
  output logic [NB_OPERAND-1:0] o_rd_retaddr,
  output logic [NB_ADDR-1:0]    o_ret_addr,
  output logic [NB_WORD-1:0]    o_mem_result,
  output logic                  o_misaligned
);

  wb_state_t state_q, state_d;
  wb_sel_t   sel;
  logic      accept;
  logic      load_done;

  logic [NB_OPERAND-1:0] ld_rd_p0;
  logic [2:0]            ld_funct3_p0;
  logic [1:0]            ld_addr_p0;

  logic [NB_WORD-1:0]    ld_value;
  logic                  ld_misaligned;

  assign sel       = wb_sel_t'(i_wb_sel);
  assign o_ready   = (state_q == IDLE);
  assign accept    = i_valid && o_ready;
  assign load_done = (state_q == LOAD_WAIT) && i_dmem_rvalid;

  load_align #(.NB_WORD(NB_WORD)) u_load_align (
    .i_rdata      (i_dmem_rdata),
    .i_funct3     (ld_funct3_p0),
    .i_addr       (ld_addr_p0),
    .o_value      (ld_value),
    .o_misaligned (ld_misaligned)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && sel == WB_LOAD) state_d = LOAD_WAIT;
      LOAD_WAIT: if (i_dmem_rvalid)            state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Stage p0: load context captured at accept, consumed when read data returns.
  always_ff @(posedge i_clock) begin
    if (accept && sel == WB_LOAD) begin
      ld_rd_p0     <= i_rd;
      ld_funct3_p0 <= i_funct3;
      ld_addr_p0   <= i_alu_result[1:0];
    end
  end

  // Output stage: strobes last one cycle, payloads hold until the next write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_write      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_value   <= '0;
      o_wr_retaddr <= 1'b0;
      o_rd_retaddr <= '0;
      o_ret_addr   <= '0;
      o_mem_result <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_write      <= 1'b0;
      o_wr_retaddr <= 1'b0;
      o_misaligned <= 1'b0;
      if (accept && sel == WB_ALU && i_rd != '0) begin
        o_write      <= 1'b1;
        o_wr_addr    <= NB_ADDR'(i_rd);
        o_wr_value   <= i_alu_result;
        o_mem_result <= i_alu_result;
      end
      if (accept && sel == WB_RET && i_rd != '0) begin
        o_wr_retaddr <= 1'b1;
        o_rd_retaddr <= i_rd;
        o_ret_addr   <= i_ret_addr;
      end
      if (load_done) begin
        if (ld_misaligned) begin
          o_misaligned <= 1'b1;
        end else if (ld_rd_p0 != '0) begin
          o_write      <= 1'b1;
          o_wr_addr    <= NB_ADDR'(ld_rd_p0);
          o_wr_value   <= ld_value;
          o_mem_result <= ld_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed table, reset/back-to-back sequences,
// and randomized transactions against an arithmetic load model.
module tb_wb_stage;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd;
  logic [1:0]  i_wb_sel;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_result;
  logic [31:0] i_ret_addr;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_write;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_value;
  logic        o_wr_retaddr;
  logic [4:0]  o_rd_retaddr;
  logic [31:0] o_ret_addr;
  logic [31:0] o_mem_result;
  logic        o_misaligned;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_mem = 32'h0;

  always #5 i_clock = ~i_clock;

  wb_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_rd(i_rd), .i_wb_sel(i_wb_sel), .i_funct3(i_funct3),
    .i_alu_result(i_alu_result), .i_ret_addr(i_ret_addr),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_write(o_write), .o_wr_addr(o_wr_addr), .o_wr_value(o_wr_value),
    .o_wr_retaddr(o_wr_retaddr), .o_rd_retaddr(o_rd_retaddr), .o_ret_addr(o_ret_addr),
    .o_mem_result(o_mem_result), .o_misaligned(o_misaligned)
  );

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ret;
    logic [31:0] rdata;
    int          waits;
    logic        e_write;
    logic [31:0] e_value;
    logic        e_retw;
    logic        e_mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference load semantics from plain shifts and masks.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int unsigned a;
    logic [31:0] b, h;
    a = addr % 4;
    b = (rdata >> (8 * a)) & 32'hFF;
    h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef WB_MISALIGN_CHECK_EN
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return (addr % 2) != 0;
    return (addr % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one instruction; on return the result cycle's outputs are stable.
  task automatic run_txn(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ret,
                         input logic [31:0] rdata, input int waits);
    @(negedge i_clock);
    chk("ready_before_accept", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1; i_wb_sel = sel; i_funct3 = f3; i_rd = rd;
    i_alu_result = alu; i_ret_addr = ret;
    i_dmem_rvalid = $urandom_range(0, 1); i_dmem_rdata = $urandom;
    @(posedge i_clock); #1;
    if (sel == 2'b10) begin
      for (int i = 0; i <= waits; i++) begin
        chk("ready_low_in_wait", {31'b0, o_ready}, 32'd0);
        chk("no_write_in_wait", {31'b0, o_write}, 32'd0);
        @(negedge i_clock);
        i_valid = 1'b1; i_wb_sel = 2'b01; i_rd = 5'd9; i_alu_result = $urandom;
        i_dmem_rvalid = (i == waits); i_dmem_rdata = (i == waits) ? rdata : $urandom;
        @(posedge i_clock); #1;
      end
    end
    i_valid = 1'b0; i_dmem_rvalid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic e_write, input logic [4:0] rd,
                              input logic [31:0] e_value, input logic e_retw,
                              input logic [31:0] e_ret, input logic e_mis);
    chk({tag, "_write"}, {31'b0, o_write}, {31'b0, e_write});
    chk({tag, "_retw"}, {31'b0, o_wr_retaddr}, {31'b0, e_retw});
    chk({tag, "_mis"}, {31'b0, o_misaligned}, {31'b0, e_mis});
    chk({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
    if (e_write) begin
      chk({tag, "_addr"}, o_wr_addr, {27'b0, rd});
      chk({tag, "_value"}, o_wr_value, e_value);
      exp_mem = e_value;
    end
    if (e_retw) begin
      chk({tag, "_rd_ret"}, {27'b0, o_rd_retaddr}, {27'b0, rd});
      chk({tag, "_ret_addr"}, o_ret_addr, e_ret);
    end
    chk({tag, "_mem_result"}, o_mem_result, exp_mem);
  endtask

  task automatic idle_cycle();
    @(negedge i_clock);
    i_valid = 1'b0; i_dmem_rvalid = $urandom_range(0, 1); i_dmem_rdata = $urandom;
    @(posedge i_clock); #1;
    i_dmem_rvalid = 1'b0;
    chk("idle_no_write", {29'b0, o_write, o_wr_retaddr, o_misaligned}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, {29'b0, o_write, o_wr_retaddr, o_misaligned}, 32'd0);
    chk({tag, "_wr_addr"}, o_wr_addr, 32'd0);
    chk({tag, "_wr_value"}, o_wr_value, 32'd0);
    chk({tag, "_rd_ret"}, {27'b0, o_rd_retaddr}, 32'd0);
    chk({tag, "_ret_addr"}, o_ret_addr, 32'd0);
    chk({tag, "_mem_result"}, o_mem_result, 32'd0);
    chk({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
  endtask

  vec_t vecs[$];
  logic mis_lw102;

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_rd = '0; i_wb_sel = '0; i_funct3 = '0;
    i_alu_result = '0; i_ret_addr = '0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
`ifdef WB_MISALIGN_CHECK_EN
    mis_lw102 = 1'b1;
`else
    mis_lw102 = 1'b0;
`endif
    vecs.push_back('{"alu_rd5",  2'b01, 3'b000, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0});
    vecs.push_back('{"lb_103",   2'b10, 3'b000, 5'd7, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0});
    vecs.push_back('{"lbu_103",  2'b10, 3'b100, 5'd7, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 3, 1'b1, 32'h0000_0080, 1'b0, 1'b0});
    vecs.push_back('{"lb_101",   2'b10, 3'b000, 5'd8, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0000_0056, 1'b0, 1'b0});
    vecs.push_back('{"lh_102",   2'b10, 3'b001, 5'd9, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 1, 1'b1, 32'hFFFF_80AA, 1'b0, 1'b0});
    vecs.push_back('{"lhu_100",  2'b10, 3'b101, 5'd10, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 0, 1'b1, 32'h0000_BBCC, 1'b0, 1'b0});
    vecs.push_back('{"lw_100",   2'b10, 3'b010, 5'd11, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 2, 1'b1, 32'h80AA_BBCC, 1'b0, 1'b0});
    vecs.push_back('{"lw_f3_011",2'b10, 3'b011, 5'd12, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back('{"lw_102",   2'b10, 3'b010, 5'd13, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, ~mis_lw102, 32'hCAFE_F00D, 1'b0, mis_lw102});
    vecs.push_back('{"ret_rd1",  2'b11, 3'b000, 5'd1, 32'h0, 32'h0000_0204, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"alu_rd0",  2'b01, 3'b000, 5'd0, 32'h5555_AAAA, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"ret_rd0",  2'b11, 3'b000, 5'd0, 32'h0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"lw_rd0",   2'b10, 3'b010, 5'd0, 32'h0000_0000, 32'h0, 32'h1111_2222, 1, 1'b0, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"none_rd3", 2'b00, 3'b000, 5'd3, 32'h7777_7777, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0});

    repeat (2) @(posedge i_clock);
    #1;
    check_all_zero("reset");
    @(negedge i_clock); i_reset = 1'b0;

    foreach (vecs[k]) begin
      run_txn(vecs[k].sel, vecs[k].f3, vecs[k].rd, vecs[k].alu, vecs[k].ret, vecs[k].rdata, vecs[k].waits);
      check_result(vecs[k].name, vecs[k].e_write, vecs[k].rd, vecs[k].e_value,
                   vecs[k].e_retw, vecs[k].ret, vecs[k].e_mis);
      idle_cycle();
    end

    // Back-to-back ALU accepts: one write per cycle, in order.
    for (int r = 2; r <= 4; r++) begin
      @(negedge i_clock);
      i_valid = 1'b1; i_wb_sel = 2'b01; i_rd = 5'(r); i_alu_result = 32'hA000_0000 + r;
      @(posedge i_clock); #1;
      check_result($sformatf("b2b_rd%0d", r), 1'b1, 5'(r), 32'hA000_0000 + r, 1'b0, 32'h0, 1'b0);
    end
    idle_cycle();

    // Reset while waiting for load data drops the load.
    @(negedge i_clock);
    i_valid = 1'b1; i_wb_sel = 2'b10; i_funct3 = 3'b010; i_rd = 5'd6; i_alu_result = 32'h40;
    @(posedge i_clock); #1;
    chk("rst_mid_ready_low", {31'b0, o_ready}, 32'd0);
    @(negedge i_clock); i_valid = 1'b0; i_reset = 1'b1;
    @(posedge i_clock); #1;
    @(negedge i_clock); i_reset = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h9999_9999;
    @(posedge i_clock); #1;
    i_dmem_rvalid = 1'b0;
    exp_mem = 32'h0;
    check_all_zero("rst_mid_load");

    // Randomized transactions against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, ret, rdata, val;
      logic        mis, ew, er;
      int          waits;
      sel = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu = $urandom; ret = $urandom; rdata = $urandom; waits = $urandom_range(0, 3);
      mis = (sel == 2'b10) && model_mis(f3, alu);
      val = (sel == 2'b10) ? model_load(rdata, f3, alu) : alu;
      ew = (rd != 0) && (sel == 2'b01 || (sel == 2'b10 && !mis));
      er = (rd != 0) && (sel == 2'b11);
      run_txn(sel, f3, rd, alu, ret, rdata, waits);
      check_result($sformatf("rand%0d", n), ew, rd, val, er, ret, mis);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
